// File: rtl/btn_reset_debounce_pkg.sv
// Shared types for the pushbutton debouncer: FSM state encoding and a
// counter-width helper that never returns a zero-width vector.
package btn_reset_debounce_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_reset_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so the output comes out of reset at the input's idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/btn_reset_debounce.sv
// Pushbutton debouncer: synchronizes a bouncing key and emits a debounced level
// plus single-cycle press, release and one-shot long-hold events.
//
//   state        | meaning
//   RELEASED     | debounced level 0, waiting for the key to go active
//   PRESS_WAIT   | key active, counting stable cycles before accepting the press
//   PRESSED      | debounced level 1, hold timer running until it fires once
//   RELEASE_WAIT | key inactive, counting stable cycles before accepting release
module btn_reset_debounce
   import btn_reset_debounce_pkg::*;
#(
   parameter int STABLE_CNT    = 50000,
   parameter int HOLD_CNT      = 0,
   parameter int ACTIVE_LOW_IN = 1
) (
   input  logic clk,
   input  logic rstb,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic hold_pulse
);

   localparam int            CW        = cnt_w(STABLE_CNT);
   localparam int            HW        = cnt_w(HOLD_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
   localparam bit            HOLD_EN   = (HOLD_CNT > 0);
   localparam logic [HW-1:0] HOLD_LAST = HOLD_EN ? HW'(HOLD_CNT - 1) : '0;
   localparam logic          IDLE_RAW  = (ACTIVE_LOW_IN != 0);

   logic sync_btn;
   logic btn_act;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          hold_done_q, hold_done_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          hold_q, hold_d;

   sync_2ff #(
      .RST_VAL (IDLE_RAW)
   ) u_sync (
      .clk  (clk),
      .rstb (rstb),
      .d    (btn_in),
      .q    (sync_btn)
   );

   assign btn_act = sync_btn ^ IDLE_RAW;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= RELEASED;
         cnt_q       <= '0;
         hold_cnt_q  <= '0;
         hold_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         hold_done_q <= hold_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         hold_q      <= hold_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_cnt_d  = hold_cnt_q;
      hold_done_d = hold_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      hold_d      = 1'b0;

      case (state_q)
         RELEASED: begin
            if (btn_act) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_act) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = PRESSED;
               level_d     = 1'b1;
               press_d     = 1'b1;
               hold_cnt_d  = '0;
               hold_done_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_act) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
            // The hold timer still advances on the edge that leaves for RELEASE_WAIT.
            if (HOLD_EN && !hold_done_q) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_d      = 1'b1;
                  hold_done_d = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
         end
         RELEASE_WAIT: begin
            if (btn_act) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = RELEASED;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RELEASED;
         end
      endcase
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign hold_pulse    = hold_q;

endmodule

// File: tb/tb_btn_reset_debounce.sv
// Bench for btn_reset_debounce: expected pulse events are queued with their
// edge number when stimulus is driven and matched as the DUT emits them.
module tb_btn_reset_debounce;

   localparam int STABLE_CNT = 4;
   localparam int HOLD_CNT   = 10;
   localparam int LAT        = STABLE_CNT + 2;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_HOLD    = 2;
   localparam int K_NONE    = 3;

   typedef struct {
      int cyc;
      int kind;
   } ev_t;

   ev_t  sb_q[$];

   logic clk    = 1'b0;
   logic rstb   = 1'b0;
   logic btn_in = 1'b1;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic hold_pulse;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   btn_reset_debounce #(
      .STABLE_CNT    (STABLE_CNT),
      .HOLD_CNT      (HOLD_CNT),
      .ACTIVE_LOW_IN (1)
   ) dut (
      .clk           (clk),
      .rstb          (rstb),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .hold_pulse    (hold_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, want %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic expect_ev(input int c, input int k);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int k);
      ev_t e;
      if (sb_q.size() == 0) begin
         chk("unexpected_pulse", k, K_NONE);
      end else begin
         e = sb_q.pop_front();
         chk("pulse_kind", k, e.kind);
         chk("pulse_edge", cyc, e.cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      step(4);
      chk(tag, sb_q.size(), 0);
      sb_q.delete();
   endtask

   always @(negedge clk) begin
      if (press_pulse) begin
         sb_pop(K_PRESS);
         chk("press_level", btn_level, 1);
      end
      if (release_pulse) begin
         sb_pop(K_RELEASE);
         chk("release_level", btn_level, 0);
      end
      if (hold_pulse) sb_pop(K_HOLD);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int f0;
      int g0;
      int r;

      // reset with key released
      rstb   = 1'b0;
      btn_in = 1'b1;
      step(3);
      chk("rst_level", btn_level, 0);
      chk("rst_press", press_pulse, 0);
      chk("rst_release", release_pulse, 0);
      chk("rst_hold", hold_pulse, 0);
      rstb = 1'b1;
      step(100);
      chk("idle_level", btn_level, 0);
      drain("idle_drain");

      // clean press, single hold event, then release
      e0     = cyc + 1;
      btn_in = 1'b0;
      expect_ev(e0 + LAT, K_PRESS);
      expect_ev(e0 + LAT + HOLD_CNT, K_HOLD);
      wait_cyc(e0 + LAT - 1);
      chk("press_pre_level", btn_level, 0);
      wait_cyc(e0 + LAT);
      chk("press_level_up", btn_level, 1);
      chk("press_pulse_hi", press_pulse, 1);
      wait_cyc(e0 + LAT + 1);
      chk("press_pulse_lo", press_pulse, 0);
      wait_cyc(e0 + LAT + HOLD_CNT + 50);
      chk("held_level", btn_level, 1);
      r      = cyc + 1;
      btn_in = 1'b1;
      expect_ev(r + LAT, K_RELEASE);
      wait_cyc(r + LAT - 1);
      chk("release_pre_level", btn_level, 1);
      wait_cyc(r + LAT);
      chk("release_level_dn", btn_level, 0);
      drain("clean_drain");

      // bounce: active for only STABLE_CNT edges is rejected
      e0     = cyc + 1;
      btn_in = 1'b0;
      step(STABLE_CNT);
      btn_in = 1'b1;
      step(20);
      chk("bounce_level", btn_level, 0);
      drain("bounce_drain");

      // active for STABLE_CNT+1 edges is accepted, then released
      e0     = cyc + 1;
      btn_in = 1'b0;
      expect_ev(e0 + LAT, K_PRESS);
      step(STABLE_CNT + 1);
      btn_in = 1'b1;
      expect_ev(e0 + STABLE_CNT + 1 + LAT, K_RELEASE);
      step(20);
      chk("short_level", btn_level, 0);
      drain("short_drain");

      // two-edge release glitch while held delays hold by two edges
      e0     = cyc + 1;
      btn_in = 1'b0;
      expect_ev(e0 + LAT, K_PRESS);
      expect_ev(e0 + LAT + HOLD_CNT + 2, K_HOLD);
      wait_cyc(e0 + 11);
      btn_in = 1'b1;
      step(2);
      btn_in = 1'b0;
      wait_cyc(e0 + 40);
      chk("glitch_level", btn_level, 1);
      r      = cyc + 1;
      btn_in = 1'b1;
      expect_ev(r + LAT, K_RELEASE);
      wait_cyc(r + LAT + 2);
      drain("glitch_drain");

      // reset during PRESS_WAIT discards the pending press
      e0     = cyc + 1;
      btn_in = 1'b0;
      wait_cyc(e0 + 3);
      #2 rstb = 1'b0;
      #1 chk("rst_wait_level", btn_level, 0);
      step(3);
      rstb = 1'b1;
      f0   = cyc + 1;
      expect_ev(f0 + LAT, K_PRESS);
      wait_cyc(f0 + LAT);
      chk("repress_level", btn_level, 1);

      // reset while PRESSED clears the level without a clock edge
      wait_cyc(f0 + LAT + 2);
      @(posedge clk);
      #2 rstb = 1'b0;
      #1 chk("async_level", btn_level, 0);
      step(2);
      rstb = 1'b1;
      g0   = cyc + 1;
      expect_ev(g0 + LAT, K_PRESS);
      wait_cyc(g0 + LAT + 1);
      r      = cyc + 1;
      btn_in = 1'b1;
      expect_ev(r + LAT, K_RELEASE);
      wait_cyc(r + LAT + 2);
      chk("final_level", btn_level, 0);
      drain("reset_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_reset_debounce.md
Name: btn_reset_debounce

Overview:
- Conditions an asynchronous, bouncing pushbutton (board reset/start key) into clean single-cycle events.
- Sits directly upstream of the reset pulse stretcher: press_pulse drives its ext_reset input.
- Also provides the debounced level, a release event and a one-shot long-hold event for the control logic of the median filter datapath.

Parameters:
- STABLE_CNT, 50000, number of consecutive debounce-wait cycles the synchronized input must stay unchanged; legal values are ≥2.
- HOLD_CNT, 0, cycles in PRESSED before hold_pulse fires; 0 disables hold detection.
- ACTIVE_LOW_IN, 1, 1 means btn_in low = pressed; 0 means btn_in high = pressed.

Ports:
- clk  input  1  system clock, single clock domain
- rstb  input  1  asynchronous, active-low reset
- btn_in  input  1  raw asynchronous button, may bounce
- btn_level  output  1  debounced level, 1 = pressed
- press_pulse  output  1  one clk high on debounced press (feeds ext_reset)
- release_pulse  output  1  one clk high on debounced release
- hold_pulse  output  1  one clk high once per press after HOLD_CNT cycles held

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstb). All flops use posedge clk / negedge rstb.
- Synchronizer: 2 flops, reset to the released raw level (ACTIVE_LOW_IN).
- btn_act = sync2 XOR ACTIVE_LOW_IN, so btn_act is active-high.
- Reset values: btn_level=0, all pulses=0, state=RELEASED, counters=0, hold_done=0.
- Debounce counter width is $clog2(STABLE_CNT). Hold counter width is $clog2(HOLD_CNT+1), minimum 1.
- FSM states and transitions, evaluated each posedge:
  - RELEASED: if btn_act=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - If btn_act=0 -> RELEASED, cnt<=0 (bounce rejected, no output).
    - Else if cnt==STABLE_CNT-1 -> PRESSED; btn_level<=1, press_pulse<=1, hold_cnt<=0, hold_done<=0.
    - Else cnt<=cnt+1.
  - PRESSED: if btn_act=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - If btn_act=1 -> PRESSED (bounce rejected). hold_cnt is not cleared; hold counting resumes.
    - Else if cnt==STABLE_CNT-1 -> RELEASED; btn_level<=0, release_pulse<=1.
    - Else cnt<=cnt+1.
- Pulse outputs are registered. Each is high for exactly one cycle and deasserts on the next edge.
- Acceptance rule: btn_act must be sampled constant on STABLE_CNT+1 consecutive edges (entry edge plus STABLE_CNT wait edges).
- Latency: if edge k is the first edge at which the synchronizer samples the new btn_in value, btn_level and the press/release pulse update at edge k+2+STABLE_CNT.
- Hold:
  - hold_cnt increments only in PRESSED while hold_done=0. It pauses during RELEASE_WAIT.
  - At the edge where hold_cnt==HOLD_CNT-1 in PRESSED: hold_pulse<=1, hold_done<=1, hold_cnt saturates. No repeat until the next debounced press.
  - HOLD_CNT=0: hold_pulse is tied to 0.
- Simultaneous events: a wait-state timeout and a btn_act change on the same edge cannot both apply; btn_act has priority (a change restarts the debounce).
- Reset mid-operation:
  - All state clears immediately, and any pending press or release is discarded.
  - If the button is still held after rstb deasserts, a fresh debounce runs and press_pulse fires normally.

Decomposition:
- Shared header (reset_pkg include): state encodings RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
- One sub-module: sync_2ff (parameter RST_VAL, ports clk, rstb, d, q). It is reused for other async inputs.

Test Plan (STABLE_CNT=4, HOLD_CNT=10, ACTIVE_LOW_IN=1):
- Reset: rstb=0 with btn_in=1 -> all outputs 0; after release, outputs stay 0 for 100 cycles.
- Clean press: btn_in 1->0 sampled at edge 0 and held -> btn_level=1 and press_pulse=1 after edge 6; press_pulse=0 after edge 7.
- Bounce rejection: btn_in low for 4 edges then high -> no pulse, btn_level stays 0. Low for 5 edges then held -> press_pulse after edge 6.
- Hold: held from clean press -> exactly one hold_pulse after edge 16; no further hold_pulse during 50 more held cycles. A 2-cycle release glitch at cycle 12 delays hold_pulse by 2 cycles and produces no release_pulse.
- Release: btn_in 0->1 at edge r while PRESSED -> release_pulse=1 and btn_level=0 after edge r+6.
- Reset mid-press: rstb low during PRESS_WAIT with btn_in held low -> outputs 0 asynchronously; press_pulse fires 6 edges after rstb deasserts (plus synchronizer refill).
